// File: rtl/bcd_seconds_display.sv
// Multi-digit BCD seconds counter (up/down, clear, load) with a prescaled count tick
// and a time-multiplexed 7-segment output with leading-zero blanking and a blinking dp.
module bcd_seconds_display #(
  parameter int CLK_HZ         = 10_000_000,
  parameter int TICK_HZ        = 1,
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 10_000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] P_HALF   = PW'(DIV / 2);
  localparam logic [RW-1:0] R_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic          SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic          DIG_INV  = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF  = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{DIG_INV}};

  logic [PW-1:0]           p_q, p_d;
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    tick_q, tick_d, wrap_q, wrap_d;
  logic [RW-1:0]           r_q, r_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic [4*NUM_DIGITS-1:0] inc_val, dec_val, clamped;
  logic                    carry, borrow, step;
  logic [3:0]              nib, cur_nib;
  logic                    nz_above, cur_nz;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   onehot;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Ripple-carry/borrow BCD neighbours and the clamped load value; a surviving
  // carry (borrow) means the count was all-9s (all-0s), i.e. this step wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    inc_val = '0;
    dec_val = '0;
    clamped = '0;
    carry   = 1'b1;
    borrow  = 1'b1;
    nib     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = count_q[4*i +: 4];
      if (!carry)          inc_val[4*i +: 4] = nib;
      else if (nib == 4'd9) inc_val[4*i +: 4] = 4'd0;
      else begin
        inc_val[4*i +: 4] = nib + 4'd1;
        carry = 1'b0;
      end
      if (!borrow)         dec_val[4*i +: 4] = nib;
      else if (nib == 4'd0) dec_val[4*i +: 4] = 4'd9;
      else begin
        dec_val[4*i +: 4] = nib - 4'd1;
        borrow = 1'b0;
      end
      nib = load_val[4*i +: 4];
      clamped[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
    end
  end

  assign step = en && (p_q == P_LAST);

  always_comb begin
    count_d = count_q;
    p_d     = p_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      p_d     = '0;
    end else if (load) begin
      count_d = clamped;
      p_d     = '0;
    end else if (step) begin
      p_d     = '0;
      tick_d  = 1'b1;
      count_d = up_dn ? inc_val : dec_val;
      wrap_d  = up_dn ? carry : borrow;
    end else if (en) begin
      p_d = p_q + PW'(1);
    end
  end

  always_comb begin
    r_d   = r_q + RW'(1);
    idx_d = idx_q;
    if (r_q == R_LAST) begin
      r_d   = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Walk digits from the top so that cur_nz says whether the selected digit or
  // anything above it is non-zero; digit 0 is always shown.
  always_comb begin
    nz_above = 1'b0;
    cur_nz   = 1'b0;
    cur_nib  = '0;
    onehot   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (count_q[4*k +: 4] != 4'd0) nz_above = 1'b1;
      if (idx_q == IW'(k)) begin
        cur_nib   = count_q[4*k +: 4];
        cur_nz    = nz_above;
        onehot[k] = 1'b1;
      end
    end
    seg_raw = (cur_nz || idx_q == '0) ? decode(cur_nib) : 7'h00;
    seg_d   = seg_raw ^ SEG_OFF;
    dp_d    = ((idx_q == '0) && (p_q < P_HALF)) ^ SEG_INV;
    sel_d   = onehot ^ SEL_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      r_q     <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= SEG_INV;
      sel_q   <= SEL_OFF;
    end else begin
      p_q     <= p_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
    end
  end

  assign count     = count_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_seconds_display.sv
// Bench for bcd_seconds_display: an arithmetic reference model checked every cycle,
// a table of load/run vectors, and hand-written sequences for the multi-cycle corners.
module tb_bcd_seconds_display;

  localparam int CLK_HZ = 8;
  localparam int ND     = 2;
  localparam int RD     = 4;
  localparam int DIV    = CLK_HZ;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk, reset, en, up_dn, clr, load;
  logic [4*ND-1:0] load_val;
  logic [4*ND-1:0] count_h, count_l;
  logic tick_h, tick_l, wrap_h, wrap_l, dp_h, dp_l;
  logic [6:0] seg_h, seg_l;
  logic [ND-1:0] sel_h, sel_l;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: plain integers, count kept as 0..10**ND-1.
  int m_count, m_p, m_r, m_idx;
  logic m_tick, m_wrap, m_dp;
  logic [6:0] m_seg;
  logic [ND-1:0] m_sel;

  bcd_seconds_display #(.CLK_HZ(CLK_HZ), .TICK_HZ(1), .NUM_DIGITS(ND), .REFRESH_DIV(RD),
                        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_h (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(count_h), .tick(tick_h), .wrap(wrap_h),
    .seg(seg_h), .dp(dp_h), .digit_sel(sel_h));

  bcd_seconds_display #(.CLK_HZ(CLK_HZ), .TICK_HZ(1), .NUM_DIGITS(ND), .REFRESH_DIV(RD),
                        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_l (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(count_l), .tick(tick_l), .wrap(wrap_l),
    .seg(seg_l), .dp(dp_l), .digit_sel(sel_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int v = 1;
    for (int i = 0; i < k; i++) v = v * 10;
    return v;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] res = '0;
    for (int k = 0; k < ND; k++) res[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return res;
  endfunction

  function automatic int clamp_val(input logic [4*ND-1:0] lv);
    int v = 0;
    int d;
    for (int k = 0; k < ND; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      v = v + d * pow10(k);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_count = 0; m_p = 0; m_r = 0; m_idx = 0;
    m_tick = 1'b0; m_wrap = 1'b0;
    m_seg = 7'h00; m_dp = 1'b0; m_sel = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int maxv = pow10(ND);
    m_seg = (m_idx > 0 && m_count < pow10(m_idx)) ? 7'h00
          : SEG_TAB[(m_count / pow10(m_idx)) % 10];
    m_dp  = (m_idx == 0) && (m_p < DIV / 2);
    m_sel = ND'(1) << m_idx;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (clr) begin
      m_count = 0; m_p = 0;
    end else if (load) begin
      m_count = clamp_val(load_val); m_p = 0;
    end else if (en && m_p == DIV - 1) begin
      m_p = 0;
      m_tick = 1'b1;
      if (up_dn) begin
        m_wrap = (m_count == maxv - 1);
        m_count = (m_count + 1) % maxv;
      end else begin
        m_wrap = (m_count == 0);
        m_count = (m_count + maxv - 1) % maxv;
      end
    end else if (en) begin
      m_p = m_p + 1;
    end
    if (m_r == RD - 1) begin
      m_r = 0;
      m_idx = (m_idx + 1) % ND;
    end else begin
      m_r = m_r + 1;
    end
  endtask

  task automatic compare_all();
    logic [6:0] seg_n;
    logic [ND-1:0] sel_n;
    logic dp_n;
    seg_n = ~m_seg;
    sel_n = ~m_sel;
    dp_n  = ~m_dp;
    check("count", count_h, to_bcd(m_count));
    check("tick", tick_h, m_tick);
    check("wrap", wrap_h, m_wrap);
    check("seg", seg_h, m_seg);
    check("dp", dp_h, m_dp);
    check("digit_sel", sel_h, m_sel);
    check("count_lowpol", count_l, to_bcd(m_count));
    check("seg_lowpol", seg_l, seg_n);
    check("dp_lowpol", dp_l, dp_n);
    check("digit_sel_lowpol", sel_l, sel_n);
  endtask

  // Inputs change just after a falling edge; outputs are compared at the next falling edge.
  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [4*ND-1:0] lv);
    en = e; up_dn = u; clr = c; load = l; load_val = lv;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [4*ND-1:0] lv;
    logic            up;
    int              n;
    logic [4*ND-1:0] exp_count;
    logic            exp_tick;
    logic            exp_wrap;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{8'h99, 1'b1, 8, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 8, 8'h99, 1'b1, 1'b1};
    vecs[2] = '{8'h99, 1'b0, 8, 8'h98, 1'b1, 1'b0};
    vecs[3] = '{8'h09, 1'b1, 8, 8'h10, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 1'b0, 8, 8'h09, 1'b1, 1'b0};
    vecs[5] = '{8'h42, 1'b1, 7, 8'h42, 1'b0, 1'b0};
    vecs[6] = '{8'hA7, 1'b1, 0, 8'h97, 1'b0, 1'b0};
    vecs[7] = '{8'hFC, 1'b0, 0, 8'h99, 1'b0, 1'b0};
    vecs[8] = '{8'h3B, 1'b1, 8, 8'h40, 1'b1, 1'b0};

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_seg_lowpol", seg_l, 7'h7F);
    check("reset_sel_lowpol", sel_l, 2'b11);
    reset = 1'b0;

    // First step lands on the 8th edge after release; digit 0 then shows "1".
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (i < 8) check("t1_no_tick_yet", tick_h, 1'b0);
    end
    check("t1_tick", tick_h, 1'b1);
    check("t1_count", count_h, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("t1_sel", sel_h, 2'b01);
    check("t1_seg", seg_h, 7'h06);

    foreach (vecs[v]) begin
      drive(1'b0, vecs[v].up, 1'b0, 1'b1, vecs[v].lv);
      for (int i = 0; i < vecs[v].n; i++) drive(1'b1, vecs[v].up, 1'b0, 1'b0, '0);
      check($sformatf("vec%0d_count", v), count_h, vecs[v].exp_count);
      check($sformatf("vec%0d_tick", v), tick_h, vecs[v].exp_tick);
      check($sformatf("vec%0d_wrap", v), wrap_h, vecs[v].exp_wrap);
    end

    // Down-count wrap, then the next step must not wrap.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (8) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t3_count", count_h, 8'h99);
    check("t3_wrap", wrap_h, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t3_wrap_pulse", wrap_h, 1'b0);
    check("t3_tick_pulse", tick_h, 1'b0);
    repeat (7) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("t3_count2", count_h, 8'h98);
    check("t3_tick2", tick_h, 1'b1);
    check("t3_wrap2", wrap_h, 1'b0);

    // clr and load beat a step on the same edge; load restarts the prescaler.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h12);
    repeat (7) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    check("t4_clr_count", count_h, 8'h00);
    check("t4_clr_tick", tick_h, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hA7);
    check("t4_clamp", count_h, 8'h97);
    repeat (7) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h34);
    check("t4_load_count", count_h, 8'h34);
    check("t4_load_tick", tick_h, 1'b0);
    repeat (8) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("t4_after_load", count_h, 8'h35);

    // Blanked upper digit and both segment polarities while frozen at 05.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      if (sel_h == 2'b01) begin
        check("t5_d0_seg", seg_h, 7'h6D);
        check("t5_d0_seg_lowpol", seg_l, 7'h12);
      end else begin
        check("t5_d1_blank", seg_h, 7'h00);
        check("t5_d1_blank_lowpol", seg_l, 7'h7F);
      end
    end

    // Prescaler hold at p=3: four enabled edges reach p=7, the fifth steps.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("t6_hold_count", count_h, 8'h00);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("t6_no_tick", tick_h, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("t6_tick", tick_h, 1'b1);
    check("t6_count", count_h, 8'h01);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("t6_async_count", count_h, 8'h00);
    check("t6_async_seg", seg_h, 7'h00);
    check("t6_async_sel", sel_h, 2'b00);
    check("t6_async_tick", tick_h, 1'b0);
    check("t6_async_seg_lowpol", seg_l, 7'h7F);
    check("t6_async_dp_lowpol", dp_l, 1'b1);
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
            (4*ND)'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
